// File: rtl/tas_pkg.sv
// Shared types and constants for the RAM write scheduler slice.
package tas_pkg;
  localparam logic [10:0] ADDR_TOP_DEFAULT = 11'h7FF;
  localparam int unsigned NUM_REQ          = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD
  } state_e;
endpackage

// File: rtl/ram_wr_sched_if.sv
// Requester handshake plus RAM write bus for ram_wr_sched.
interface ram_wr_sched_if;
  import tas_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [7:0]         data0;
  logic [7:0]         data1;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic               ram_wr_n;
  logic [7:0]         ram_data;
  logic [10:0]        ram_addr;
  logic               busy;
  logic               wrap;

  modport master (
    output req, data0, data1,
    input  gnt, done, ram_wr_n, ram_data, ram_addr, busy, wrap
  );

  modport slave (
    input  req, data0, data1,
    output gnt, done, ram_wr_n, ram_data, ram_addr, busy, wrap
  );
endinterface

// File: rtl/ram_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter; last_q holds the index of the requester served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  logic last_q, last_d;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    last_d = update ? gnt[1] : last_q;
  end

  // Reset value 1 means requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/ram_wr_sched.sv
// Arbitrates two byte writers onto an async-SRAM style write port, filling downward from ADDR_TOP.
module ram_wr_sched
  import tas_pkg::*;
#(
  parameter logic [10:0] ADDR_TOP      = ADDR_TOP_DEFAULT,
  parameter int unsigned WR_LOW_CYCLES = 2
) (
  input  logic          clk_50,
  input  logic          reset_n,
  ram_wr_sched_if.slave bus
);
  localparam logic [3:0] LOW_INIT = 4'(WR_LOW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic [10:0]        addr_q, addr_d;
  logic [10:0]        ptr_q, ptr_d;
  logic               wr_n_q, wr_n_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               win_q, win_d;
  logic [3:0]         cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;

  rr_arb2 u_arb (
    .clk    (clk_50),
    .rst_n  (reset_n),
    .req    (bus.req),
    .update (accept),
    .gnt    (arb_gnt)
  );

  // Arbiter grants only reach the requesters while idle and out of reset.
  assign gnt    = (reset_n && state_q == IDLE) ? arb_gnt : '0;
  assign accept = |gnt;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    wr_n_d  = wr_n_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          win_d   = gnt[1];
          data_d  = gnt[1] ? bus.data1 : bus.data0;
          addr_d  = ptr_q;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wr_n_d  = 1'b0;
        cnt_d   = LOW_INIT;
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b1;
          done_d  = win_q ? 2'b10 : 2'b01;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        if (ptr_q == '0) begin
          ptr_d  = ADDR_TOP;
          wrap_d = 1'b1;
        end else begin
          ptr_d = ptr_q - 11'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= ADDR_TOP;
      ptr_q   <= ADDR_TOP;
      wr_n_q  <= 1'b1;
      done_q  <= '0;
      wrap_q  <= 1'b0;
      win_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      wr_n_q  <= wr_n_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.done     = done_q;
  assign bus.ram_wr_n = wr_n_q;
  assign bus.ram_data = data_q;
  assign bus.ram_addr = addr_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: one default instance plus WR_LOW_CYCLES=1 and 15 variants.
module tb_ram_wr_sched;
  logic clk_50  = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_50 = ~clk_50;

  ram_wr_sched_if bus ();
  ram_wr_sched_if bus1 ();
  ram_wr_sched_if bus15 ();

  ram_wr_sched u_dut (.clk_50(clk_50), .reset_n(reset_n), .bus(bus));
  ram_wr_sched #(.WR_LOW_CYCLES(1))  u_dut1  (.clk_50(clk_50), .reset_n(reset_n), .bus(bus1));
  ram_wr_sched #(.WR_LOW_CYCLES(15)) u_dut15 (.clk_50(clk_50), .reset_n(reset_n), .bus(bus15));

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  // Observations of the default instance, sampled on falling edges.
  int unsigned aq[$], wst[$], wwid[$], dcy[$], wrc[$];
  logic [10:0] wad[$];
  logic [7:0]  wda[$];
  logic [1:0]  dval[$];
  bit          in_low = 1'b0;
  int unsigned cur_w, cur_st;
  logic [10:0] cur_a;
  logic [7:0]  cur_d;

  always @(posedge clk_50) cyc++;

  always @(negedge clk_50) begin
    if (!reset_n) in_low = 1'b0;
    else begin
      if ((bus.req & bus.gnt) != 2'b00) aq.push_back(cyc);
      if (bus.done != 2'b00) begin dval.push_back(bus.done); dcy.push_back(cyc); end
      if (bus.wrap) wrc.push_back(cyc);
      if (!bus.ram_wr_n) begin
        if (!in_low) begin
          in_low = 1'b1; cur_w = 0; cur_st = cyc; cur_a = bus.ram_addr; cur_d = bus.ram_data;
        end
        cur_w++;
      end else if (in_low) begin
        in_low = 1'b0;
        wst.push_back(cur_st); wwid.push_back(cur_w); wad.push_back(cur_a); wda.push_back(cur_d);
      end
    end
  end

  task automatic clear_q();
    aq.delete(); wst.delete(); wwid.delete(); dcy.delete(); wrc.delete();
    wad.delete(); wda.delete(); dval.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = '0; bus1.req = '0; bus15.req = '0;
    repeat (2) @(posedge clk_50);
    #1;
    clear_q();
    reset_n = 1'b1;
  endtask

  // Returns just after the edge that performs the n-th accept.
  task automatic wait_acc(input int unsigned n, input int unsigned budget, output bit to);
    int unsigned i = 0;
    to = 1'b1;
    while (i < budget && to) begin
      @(negedge clk_50);
      if (aq.size() >= n) to = 1'b0;
      i++;
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic wait_done(input int unsigned n, input int unsigned budget, output bit to);
    int unsigned i = 0;
    to = 1'b1;
    while (i < budget && to) begin
      @(negedge clk_50);
      if (dval.size() >= n) to = 1'b0;
      i++;
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 2'b11; bus.data0 = 8'hAA; bus.data1 = 8'h55;
    bus1.req = '0; bus15.req = '0;
    bus1.data0 = '0; bus1.data1 = '0; bus15.data0 = '0; bus15.data1 = '0;
    #2 reset_n = 1'b0;
    #2;
    total++; if (bus.ram_wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b exp=1", bus.ram_wr_n); end
    total++; if (bus.ram_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.ram_data); end
    total++; if (bus.ram_addr !== 11'h7FF) begin bad++; $display("FAIL rst_addr got=%h exp=7ff", bus.ram_addr); end
    total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", bus.gnt); end
    total++; if (bus.done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL rst_wrap got=%b exp=0", bus.wrap); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    repeat (2) @(posedge clk_50);
    #1 reset_n = 1'b1;
    @(negedge clk_50);
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL rst_prio got=%b exp=01", bus.gnt); end
    @(posedge clk_50);
    #1 bus.req = '0;
  endtask

  task automatic test_single();
    bit to;
    do_reset();
    bus.data0 = 8'h3C; bus.req = 2'b01;
    @(negedge clk_50);
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b exp=01", bus.gnt); end
    @(posedge clk_50);
    #1 bus.req = '0; bus.data0 = 8'hFF;
    @(negedge clk_50);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    wait_done(1, 20, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b exp=0", to); end
    if (!to) begin
      total++; if (wad[0] !== 11'h7FF) begin bad++; $display("FAIL single_addr got=%h exp=7ff", wad[0]); end
      total++; if (wda[0] !== 8'h3C) begin bad++; $display("FAIL single_data got=%h exp=3c", wda[0]); end
      total++; if (wwid[0] !== 2) begin bad++; $display("FAIL single_width got=%0d exp=2", wwid[0]); end
      total++; if (wst[0] - aq[0] !== 2) begin bad++; $display("FAIL single_lowlat got=%0d exp=2", wst[0] - aq[0]); end
      total++; if (dval[0] !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", dval[0]); end
      total++; if (dcy[0] - aq[0] !== 4) begin bad++; $display("FAIL single_donelat got=%0d exp=4", dcy[0] - aq[0]); end
    end
    bus.data1 = 8'h5A; bus.req = 2'b10;
    wait_acc(2, 10, to);
    bus.req = '0;
    wait_done(2, 20, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL second_timeout got=%b exp=0", to); end
    if (!to) begin
      total++; if (wad[1] !== 11'h7FE) begin bad++; $display("FAIL second_addr got=%h exp=7fe", wad[1]); end
      total++; if (dval[1] !== 2'b10) begin bad++; $display("FAIL second_done got=%b exp=10", dval[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [7:0] exp_d;
    logic [1:0] exp_v;
    do_reset();
    bus.data0 = 8'h11; bus.data1 = 8'h22; bus.req = 2'b11;
    wait_acc(4, 40, to);
    bus.req = '0;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_acc_timeout got=%b exp=0", to); end
    wait_done(4, 40, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_done_timeout got=%b exp=0", to); end
    total++; if (aq.size() !== 4) begin bad++; $display("FAIL b2b_accepts got=%0d exp=4", aq.size()); end
    if (!to && aq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
        exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
        total++; if (wda[i] !== exp_d) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, wda[i], exp_d); end
        total++; if (wad[i] !== 11'h7FF - 11'(i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, wad[i], 11'h7FF - 11'(i)); end
        total++; if (dval[i] !== exp_v) begin bad++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, dval[i], exp_v); end
        if (i > 0) begin
          total++; if (aq[i] - aq[i-1] !== 5) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=5", i, aq[i] - aq[i-1]); end
        end
      end
    end
  endtask

  task automatic test_inflight();
    bit to;
    do_reset();
    bus.data1 = 8'hA5; bus.req = 2'b10;
    @(negedge clk_50);
    total++; if (bus.gnt !== 2'b10) begin bad++; $display("FAIL infl_gnt got=%b exp=10", bus.gnt); end
    wait_acc(1, 5, to);
    bus.req = '0; bus.data1 = 8'h5A;
    wait_done(1, 20, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL infl_timeout got=%b exp=0", to); end
    if (!to) begin
      total++; if (wda[0] !== 8'hA5) begin bad++; $display("FAIL infl_data got=%h exp=a5", wda[0]); end
      total++; if (wad[0] !== 11'h7FF) begin bad++; $display("FAIL infl_addr got=%h exp=7ff", wad[0]); end
      total++; if (dval[0] !== 2'b10) begin bad++; $display("FAIL infl_done got=%b exp=10", dval[0]); end
    end
  endtask

  task automatic test_reset_mid_write();
    bit to;
    bit low_seen = 1'b0;
    do_reset();
    bus.data0 = 8'h77; bus.req = 2'b01;
    wait_acc(1, 10, to);
    bus.req = '0;
    for (int i = 0; i < 10 && !low_seen; i++) begin
      @(negedge clk_50);
      if (!bus.ram_wr_n) low_seen = 1'b1;
    end
    total++; if (low_seen !== 1'b1) begin bad++; $display("FAIL midrst_low_seen got=%b exp=1", low_seen); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.ram_wr_n !== 1'b1) begin bad++; $display("FAIL midrst_wr_n got=%b exp=1", bus.ram_wr_n); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    repeat (2) @(posedge clk_50);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk_50);
    #1;
    total++; if (dval.size() !== 1 - 1) begin bad++; $display("FAIL midrst_nodone got=%0d exp=0", dval.size()); end
    clear_q();
    bus.data0 = 8'h88; bus.req = 2'b01;
    wait_acc(1, 10, to);
    bus.req = '0;
    wait_done(1, 20, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL midrst_timeout got=%b exp=0", to); end
    if (!to) begin
      total++; if (wad[0] !== 11'h7FF) begin bad++; $display("FAIL midrst_addr got=%h exp=7ff", wad[0]); end
      total++; if (wda[0] !== 8'h88) begin bad++; $display("FAIL midrst_data got=%h exp=88", wda[0]); end
    end
  endtask

  task automatic test_low_width();
    int f1 = -1, w1 = 0, dk1 = -1;
    int f15 = -1, w15 = 0, dk15 = -1;
    logic [1:0] dv1 = '0, dv15 = '0;
    logic [7:0] d1 = '0, d15 = '0;
    logic [10:0] a15 = '0;
    do_reset();
    bus1.data0 = 8'hC3; bus1.req = 2'b01;
    bus15.data1 = 8'h3C; bus15.req = 2'b10;
    @(negedge clk_50);
    total++; if (bus1.gnt !== 2'b01) begin bad++; $display("FAIL w1_gnt got=%b exp=01", bus1.gnt); end
    total++; if (bus15.gnt !== 2'b10) begin bad++; $display("FAIL w15_gnt got=%b exp=10", bus15.gnt); end
    @(posedge clk_50);
    #1 bus1.req = '0; bus15.req = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_50);
      if (!bus1.ram_wr_n) begin if (f1 < 0) begin f1 = k; d1 = bus1.ram_data; end w1++; end
      if (bus1.done != 2'b00) begin dk1 = k; dv1 = bus1.done; end
      if (!bus15.ram_wr_n) begin if (f15 < 0) begin f15 = k; d15 = bus15.ram_data; a15 = bus15.ram_addr; end w15++; end
      if (bus15.done != 2'b00) begin dk15 = k; dv15 = bus15.done; end
    end
    total++; if (f1 !== 2) begin bad++; $display("FAIL w1_lowstart got=%0d exp=2", f1); end
    total++; if (w1 !== 1) begin bad++; $display("FAIL w1_width got=%0d exp=1", w1); end
    total++; if (dk1 !== 3) begin bad++; $display("FAIL w1_donelat got=%0d exp=3", dk1); end
    total++; if (dv1 !== 2'b01) begin bad++; $display("FAIL w1_done got=%b exp=01", dv1); end
    total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL w1_data got=%h exp=c3", d1); end
    total++; if (f15 !== 2) begin bad++; $display("FAIL w15_lowstart got=%0d exp=2", f15); end
    total++; if (w15 !== 15) begin bad++; $display("FAIL w15_width got=%0d exp=15", w15); end
    total++; if (dk15 !== 17) begin bad++; $display("FAIL w15_donelat got=%0d exp=17", dk15); end
    total++; if (dv15 !== 2'b10) begin bad++; $display("FAIL w15_done got=%b exp=10", dv15); end
    total++; if (d15 !== 8'h3C) begin bad++; $display("FAIL w15_data got=%h exp=3c", d15); end
    total++; if (a15 !== 11'h7FF) begin bad++; $display("FAIL w15_addr got=%h exp=7ff", a15); end
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    bus.data0 = 8'h96; bus.req = 2'b01;
    wait_acc(2049, 2049 * 5 + 20, to);
    bus.req = '0;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wrap_acc_timeout got=%b exp=0", to); end
    wait_done(2049, 30, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wrap_done_timeout got=%b exp=0", to); end
    total++; if (wrc.size() !== 1) begin bad++; $display("FAIL wrap_count got=%0d exp=1", wrc.size()); end
    if (!to && wrc.size() >= 1) begin
      total++; if (wad[2046] !== 11'h001) begin bad++; $display("FAIL wrap_addr2047 got=%h exp=001", wad[2046]); end
      total++; if (wad[2047] !== 11'h000) begin bad++; $display("FAIL wrap_addr2048 got=%h exp=000", wad[2047]); end
      total++; if (wad[2048] !== 11'h7FF) begin bad++; $display("FAIL wrap_addr2049 got=%h exp=7ff", wad[2048]); end
      total++; if (wrc[0] !== dcy[2047] + 1) begin bad++; $display("FAIL wrap_timing got=%0d exp=%0d", wrc[0], dcy[2047] + 1); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_inflight();
    test_reset_mid_write();
    test_low_width();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
